// File: rtl/seg_display_driver_pkg.sv
// Shared constants for the seven-segment display path: segment codes,
// counter widths and the default PWM prescale.
package seg_display_driver_pkg;

  localparam int unsigned PRESCALE_DEFAULT = 16;
  localparam int unsigned PRE_W            = 16;
  localparam int unsigned PWM_W            = 8;
  localparam int unsigned IDX_W            = 2;
  localparam int unsigned NIB_W            = 4;
  localparam int unsigned SEG_W            = 7;
  localparam int unsigned NUM_DIGITS       = 4;

  // Active-low cathode codes, bit order g..a
  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  localparam logic [SEG_W:0]        CATHODES_OFF = 8'hFF;
  localparam logic [NUM_DIGITS-1:0] ANODES_OFF   = 4'hF;

  // Active-low one-hot anode enable for a digit index
  function automatic logic [NUM_DIGITS-1:0] anode_enable(input logic [IDX_W-1:0] idx);
    return ~NUM_DIGITS'(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg_display_driver_seg7_decode.sv
// Combinational BCD nibble to active-low seven-segment decode; non-BCD codes blank.
module seg7_decode
  import seg_display_driver_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] segments_c
);

  always_comb begin
    segments_c = SEG_BLANK;
    case (nibble)
      4'd0:    segments_c = SEG_0;
      4'd1:    segments_c = SEG_1;
      4'd2:    segments_c = SEG_2;
      4'd3:    segments_c = SEG_3;
      4'd4:    segments_c = SEG_4;
      4'd5:    segments_c = SEG_5;
      4'd6:    segments_c = SEG_6;
      4'd7:    segments_c = SEG_7;
      4'd8:    segments_c = SEG_8;
      4'd9:    segments_c = SEG_9;
      default: segments_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_display_driver.sv
// Four-digit multiplexed seven-segment driver with per-slot PWM brightness
// and input latching at each digit slot start.
module seg_display_driver
  import seg_display_driver_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
  input  logic                   Clk_100M,
  input  logic                   Reset_Button,
  input  logic [15:0]            Digits,
  input  logic                   Colon,
  input  logic [PWM_W-1:0]       Brightness,
  output logic [NUM_DIGITS-1:0]  SegmentDrivers,
  output logic [SEG_W:0]         SevenSegment
);

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
  localparam logic [PWM_W-1:0] PWM_MAX = '1;
  localparam logic [IDX_W-1:0] DP_IDX  = 2'd2;

  logic [PRE_W-1:0] pre;
  logic [PWM_W-1:0] pwm;
  logic [IDX_W-1:0] idx;

  logic [15:0]      digits_q;
  logic             colon_q;
  logic [PWM_W-1:0] bright_q;

  logic             pre_wrap_c;
  logic             slot_start_c;
  logic [15:0]      digits_c;
  logic             colon_c;
  logic [PWM_W-1:0] bright_c;
  logic [NIB_W-1:0] nibble_c;
  logic [SEG_W-1:0] segments_c;
  logic             anode_on_c;

  assign pre_wrap_c   = (pre == PRE_MAX);
  assign slot_start_c = (pre == '0) && (pwm == '0);

  // The slot-start cycle displays the freshly sampled inputs, later cycles the latched copy
  assign digits_c   = slot_start_c ? Digits     : digits_q;
  assign colon_c    = slot_start_c ? Colon      : colon_q;
  assign bright_c   = slot_start_c ? Brightness : bright_q;
  assign nibble_c   = digits_c[{idx, 2'b00} +: NIB_W];
  assign anode_on_c = (pwm < bright_c);

  seg7_decode u_decode (
    .nibble     (nibble_c),
    .segments_c (segments_c)
  );

  // Prescale, PWM step and digit index counters
  always_ff @(posedge Clk_100M) begin
    if (Reset_Button) begin
      pre <= '0;
      pwm <= '0;
      idx <= '0;
    end else begin
      pre <= pre_wrap_c ? '0 : PRE_W'(pre + 1'b1);
      if (pre_wrap_c) begin
        pwm <= PWM_W'(pwm + 1'b1);
        if (pwm == PWM_MAX) begin
          idx <= IDX_W'(idx + 1'b1);
        end
      end
    end
  end

  // Slot-start input latches
  always_ff @(posedge Clk_100M) begin
    if (Reset_Button) begin
      digits_q <= '0;
      colon_q  <= 1'b0;
      bright_q <= '0;
    end else if (slot_start_c) begin
      digits_q <= Digits;
      colon_q  <= Colon;
      bright_q <= Brightness;
    end
  end

  // Registered outputs; cathodes are forced off with the anode to avoid ghosting
  always_ff @(posedge Clk_100M) begin
    if (Reset_Button) begin
      SegmentDrivers <= ANODES_OFF;
      SevenSegment   <= CATHODES_OFF;
    end else if (anode_on_c) begin
      SegmentDrivers <= anode_enable(idx);
      SevenSegment   <= {~((idx == DP_IDX) && colon_c), segments_c};
    end else begin
      SegmentDrivers <= ANODES_OFF;
      SevenSegment   <= CATHODES_OFF;
    end
  end

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver at PRESCALE=1 (256-clock digit slots).
module tb_seg_display_driver;

  logic       clk = 1'b0;
  logic       reset_button;
  logic [15:0] digits;
  logic       colon;
  logic [7:0] brightness;
  logic [3:0] segment_drivers;
  logic [7:0] seven_segment;

  int checks = 0;
  int errors = 0;

  seg_display_driver #(.PRESCALE(1)) dut (
    .Clk_100M       (clk),
    .Reset_Button   (reset_button),
    .Digits         (digits),
    .Colon          (colon),
    .Brightness     (brightness),
    .SegmentDrivers (segment_drivers),
    .SevenSegment   (seven_segment)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs n_ticks clocks of a slot; anode on for the first on_clks, optional mid-slot Digits change
  task automatic run_slot(input string tag, input logic [3:0] an, input logic [7:0] seg,
                          input int on_clks, input int n_ticks,
                          input int chg_at, input logic [15:0] chg_val);
    for (int n = 1; n <= n_ticks; n++) begin
      tick();
      if (n <= on_clks) begin
        check({tag, "_an"},  {4'h0, segment_drivers}, {4'h0, an});
        check({tag, "_seg"}, seven_segment, seg);
      end else begin
        check({tag, "_an_off"},  {4'h0, segment_drivers}, 8'h0F);
        check({tag, "_seg_off"}, seven_segment, 8'hFF);
      end
      if (n == chg_at) digits = chg_val;
    end
  endtask

  initial begin
    reset_button = 1'b1;
    digits       = 16'h1234;
    colon        = 1'b0;
    brightness   = 8'hFF;

    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_an",  {4'h0, segment_drivers}, 8'h0F);
      check("rst_seg", seven_segment, 8'hFF);
    end
    reset_button = 1'b0;

    // Full brightness: 255 of 256 steps on, digits 4,3,2,1
    run_slot("ff_d0", 4'b1110, 8'h99, 255, 256, -1, 16'h0);
    run_slot("ff_d1", 4'b1101, 8'hB0, 255, 256, -1, 16'h0);
    run_slot("ff_d2", 4'b1011, 8'hA4, 255, 256, -1, 16'h0);
    run_slot("ff_d3", 4'b0111, 8'hF9, 255, 256, -1, 16'h0);

    brightness = 8'h40;
    run_slot("b40_d0", 4'b1110, 8'h99, 64, 256, -1, 16'h0);
    run_slot("b40_d1", 4'b1101, 8'hB0, 64, 256, -1, 16'h0);
    run_slot("b40_d2", 4'b1011, 8'hA4, 64, 256, -1, 16'h0);
    run_slot("b40_d3", 4'b0111, 8'hF9, 64, 256, -1, 16'h0);

    brightness = 8'h00;
    run_slot("b00_d0", 4'b1110, 8'h99, 0, 256, -1, 16'h0);
    run_slot("b00_d1", 4'b1101, 8'hB0, 0, 256, -1, 16'h0);
    run_slot("b00_d2", 4'b1011, 8'hA4, 0, 256, -1, 16'h0);
    run_slot("b00_d3", 4'b0111, 8'hF9, 0, 256, -1, 16'h0);

    // Blank codes and decimal point on digit 2
    brightness = 8'hFF;
    digits     = 16'hFA09;
    colon      = 1'b1;
    run_slot("blk_d0", 4'b1110, 8'h90, 255, 256, -1, 16'h0);
    run_slot("blk_d1", 4'b1101, 8'hC0, 255, 256, -1, 16'h0);
    run_slot("blk_d2", 4'b1011, 8'h7F, 255, 256, -1, 16'h0);
    run_slot("blk_d3", 4'b0111, 8'hFF, 255, 256, -1, 16'h0);

    // Mid-slot Digits change takes effect only at the next slot
    digits = 16'h0000;
    colon  = 1'b0;
    run_slot("lat_d0", 4'b1110, 8'hC0, 255, 256, -1, 16'h0);
    run_slot("lat_d1", 4'b1101, 8'hC0, 255, 256, 100, 16'h9999);
    run_slot("lat_d2", 4'b1011, 8'h90, 255, 130, -1, 16'h0);

    // Reset mid-slot aborts it; release starts a full digit-0 slot
    reset_button = 1'b1;
    tick();
    check("mid_rst_an",  {4'h0, segment_drivers}, 8'h0F);
    check("mid_rst_seg", seven_segment, 8'hFF);
    reset_button = 1'b0;
    run_slot("post_rst_d0", 4'b1110, 8'h90, 255, 256, -1, 16'h0);
    run_slot("post_rst_d1", 4'b1101, 8'h90, 1, 1, -1, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_display_driver.md
SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 16, giving clocks per PWM step (legal range 1..65535).
REQ-002 The block SHALL have input Clk_100M, 1 bit: the single system clock, rising-edge active.
REQ-003 The block SHALL have input Reset_Button, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have input Digits, 16 bits: four BCD nibbles from the time-keeping counter (D3 = [15:12] hours-tens … D0 = [3:0] minutes-units).
REQ-005 The block SHALL have input Colon, 1 bit: requests the decimal point lit on digit 2.
REQ-006 The block SHALL have input Brightness, 8 bits: PWM on-level taken from the slide switches.
REQ-007 The block SHALL have output SegmentDrivers, 4 bits: active-low anode enables, bit n selects digit n.
REQ-008 The block SHALL have output SevenSegment, 8 bits: active-low cathodes, [6:0] = g..a, [7] = DP.

Function
REQ-009 Counters SHALL be: pre (0..PRESCALE-1, +1 each clock); pwm (8-bit, +1 when pre wraps); idx (2-bit, +1 when pwm wraps 255->0 and pre wraps, 3->0 wrap).
REQ-010 A digit slot SHALL be 256*PRESCALE clocks; full scan SHALL be 1024*PRESCALE clocks; digits SHALL be scanned in the order 0,1,2,3,0.
REQ-011 At each slot start (pre=0, pwm=0), Digits, Colon and Brightness SHALL be latched; mid-slot input changes SHALL have no effect until the next slot.
REQ-012 SegmentDrivers SHALL be the active-low one-hot of idx when pwm < latched Brightness, else 4'b1111.
REQ-013 Brightness 0x00 SHALL give anodes always off; 0xFF SHALL give 255 of 256 steps on.
REQ-014 SevenSegment[6:0] SHALL decode the latched nibble for idx: 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90 (hex, DP bit 1).
REQ-015 Nibbles 10..15 SHALL produce blank (SevenSegment = 8'hFF).
REQ-016 SevenSegment[7] SHALL be 0 only when idx = 2 and latched Colon = 1.
REQ-017 Both outputs SHALL be registered, lagging counter state by exactly one clock.
REQ-018 When the anode is off, SevenSegment SHALL be 8'hFF (no ghosting on the next digit).

Reset
REQ-019 While Reset_Button is high at a clock edge, pre, pwm and idx SHALL become 0 and the latches SHALL become 0.
REQ-020 On that same edge, SegmentDrivers SHALL become 4'b1111 and SevenSegment SHALL become 8'hFF.
REQ-021 Reset asserted mid-slot SHALL abort the slot, and the first clock after release SHALL be a slot start for digit 0.
REQ-022 No asynchronous reset path SHALL exist.

Structure
REQ-023 The segment code constants and the PRESCALE default SHALL live in a shared package/include used by the time-keeping block and its bench.
REQ-024 The nibble-to-segment decode SHALL be one combinational sub-module, seg7_decode (4-bit in, 7-bit out, blank for >9).
REQ-025 Total RTL SHALL be 120-400 lines.

Verification (PRESCALE=1, slot = 256 clocks)
REQ-026 Reset held 3 clocks, then released, Digits=16'h1234, Brightness=FF -> outputs 4'b1111/8'hFF during reset; in slot 0, SegmentDrivers=4'b1110, SevenSegment=8'h99 for pwm 0..254; anode off at pwm 255.
REQ-027 Brightness=8'h40 -> each slot shows anode on for exactly 64 clocks, off for 192.
REQ-028 Brightness=8'h00 -> SegmentDrivers stays 4'b1111 for a full 1024-clock scan.
REQ-029 Digits=16'hFA09, Colon=1 -> digit0 8'h90, digit1 8'hC0, digit2 8'h7F (blank plus DP), digit3 8'hFF.
REQ-030 Digits changed from 16'h0000 to 16'h9999 at clock 100 of slot 1 -> slot 1 keeps showing 8'hC0; slot 2 shows 8'h90.
REQ-031 Reset pulsed at clock 130 of slot 2 -> outputs off next clock; after release, a full 256-clock digit-0 slot begins.
